// File: rtl/lsu_sram.sv
// Memory-stage load/store unit: alignment check, SRAM-like bus handshake,
// load data alignment/extension and pipeline stall generation.
module lsu_sram #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] load_result,
  output logic              load_valid,
  output logic              stall_o,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_CANCEL = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic              r_cancel, r_is_load;
  logic              r_req, r_wr, r_load_valid;
  logic [1:0]        r_size, r_a;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_load_result;
  logic [3:0]        r_wstrb;

  logic              w_access, w_misalign, w_start, w_cancel, w_capture;
  logic [1:0]        w_size;
  logic [DATA_W-1:0] w_wdata, w_ext;
  logic [3:0]        w_wstrb;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  // Access qualification and alignment
  assign w_access   = valid_i & (mem_read | mem_write) & ~flush;
  assign w_misalign = (mem_op[1:0] == 2'b01) ? addr_i[0] :
                      (mem_op[1:0] == 2'b00) ? 1'b0 : (addr_i[1:0] != 2'b00);
  assign adel       = w_access & mem_read  & w_misalign;
  assign ades       = w_access & mem_write & w_misalign;
  assign badvaddr   = addr_i;
  assign w_start    = (r_state == S_IDLE) & w_access & ~w_misalign;
  assign w_size     = (mem_op[1:0] == 2'b11) ? 2'd2 : mem_op[1:0];

  // Store lane replication and byte enables
  always_comb begin
    w_wdata = wdata_i;
    w_wstrb = 4'b1111;
    case (w_size)
      2'd0: begin
        w_wdata = {4{wdata_i[7:0]}};
        w_wstrb = 4'b0001 << addr_i[1:0];
      end
      2'd1: begin
        w_wdata = {2{wdata_i[15:0]}};
        w_wstrb = 4'b0011 << addr_i[1:0];
      end
      default: ;
    endcase
    if (!mem_write) w_wstrb = 4'b0000;
  end

  // Load extraction from the latched low address bits and op
  assign w_byte = data_rdata[{r_a, 3'b000} +: 8];
  assign w_half = data_rdata[{r_a[1], 4'b0000} +: 16];
  always_comb begin
    w_ext = data_rdata;
    case (r_op[1:0])
      2'b00: w_ext = r_op[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01: w_ext = r_op[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: ;
    endcase
  end

  // A flush seen in REQ/WAIT applies in the same cycle it arrives
  assign w_cancel  = r_cancel | flush;
  assign w_capture = data_data_ok & ~w_cancel & r_is_load &
                     (((r_state == S_REQ) & data_addr_ok) | (r_state == S_WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_REQ;
      S_REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) w_next = w_cancel ? S_IDLE : S_DONE;
          else              w_next = w_cancel ? S_CANCEL : S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_data_ok) w_next = w_cancel ? S_IDLE : S_DONE;
        else if (flush)   w_next = S_CANCEL;
      end
      S_DONE:   w_next = S_IDLE;
      S_CANCEL: if (data_data_ok) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus fields latched at issue and held for the whole transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req         <= 1'b0;
      r_wr          <= 1'b0;
      r_size        <= 2'd0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= 4'b0000;
      r_a           <= 2'd0;
      r_op          <= 3'd0;
      r_is_load     <= 1'b0;
      r_cancel      <= 1'b0;
      r_load_result <= '0;
      r_load_valid  <= 1'b0;
    end else begin
      r_req        <= (w_next == S_REQ);
      r_load_valid <= (w_next == S_DONE) & r_is_load;
      if (w_start) begin
        r_wr      <= mem_write;
        r_size    <= w_size;
        r_addr    <= addr_i;
        r_wdata   <= w_wdata;
        r_wstrb   <= w_wstrb;
        r_a       <= addr_i[1:0];
        r_op      <= mem_op;
        r_is_load <= mem_read;
      end
      if (w_next == S_IDLE)
        r_cancel <= 1'b0;
      else if (((r_state == S_REQ) | (r_state == S_WAIT)) & flush)
        r_cancel <= 1'b1;
      if (w_capture) r_load_result <= w_ext;
    end
  end

  assign data_req    = r_req;
  assign data_wr     = r_wr;
  assign data_size   = r_size;
  assign data_addr   = r_addr;
  assign data_wdata  = r_wdata;
  assign data_wstrb  = r_wstrb;
  assign load_result = r_load_result;
  assign load_valid  = r_load_valid;
  assign stall_o     = w_start | (r_state == S_REQ) | (r_state == S_WAIT) |
                       ((r_state == S_CANCEL) & valid_i);

endmodule

// File: tb/tb_lsu_sram.sv
// Directed bench for lsu_sram: expected load results are queued at issue and
// compared when load_valid fires; bus/strobe/exception fields checked inline.
module tb_lsu_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, mem_read, mem_write, flush;
  logic [2:0]  mem_op;
  logic [31:0] addr_i, wdata_i;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] load_result;
  logic        load_valid, stall_o, adel, ades;
  logic [31:0] badvaddr;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  lsu_sram dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read(mem_read),
    .mem_write(mem_write), .mem_op(mem_op), .addr_i(addr_i), .wdata_i(wdata_i),
    .flush(flush), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .load_result(load_result), .load_valid(load_valid),
    .stall_o(stall_o), .adel(adel), .ades(ades), .badvaddr(badvaddr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every load_valid must match the oldest queued load
  always @(negedge clk) begin
    if (rst === 1'b1 && load_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_load_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("load_result", load_result, e);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Wait for a request, accept it, then return data one cycle later; ends in DONE
  task automatic bus_xact(input logic [31:0] rd);
    int n = 0;
    while (data_req !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check("bus_req_seen", 32'(data_req), 32'd1);
    if (data_req === 1'b1) begin
      data_addr_ok = 1'b1;
      cyc();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b1;
      data_rdata   = rd;
      cyc();
      data_data_ok = 1'b0;
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd);
    valid_i = 1'b1; mem_read = rd; mem_write = wr; mem_op = op;
    addr_i = a; wdata_i = wd;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    drive(1'b1, 1'b0, op, a, 32'h0);
    sb.push_back(exp);
    bus_xact(rd);
    idle_inputs();
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; flush = 1'b0; idle_inputs(); mem_op = 3'd0;
    addr_i = 32'h0; wdata_i = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    cyc(); cyc();
    check("rst_data_req",    32'(data_req),   32'd0);
    check("rst_data_wstrb",  32'(data_wstrb), 32'd0);
    check("rst_load_result", load_result,     32'd0);
    check("rst_stall",       32'(stall_o),    32'd0);
    rst = 1'b1;
    cyc();

    // LW with addr_ok in cycle 2 and data_ok in cycle 4
    drive(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'h0);
    sb.push_back(32'hDEAD_BEEF);
    #1 check("lw_c0_stall", 32'(stall_o), 32'd1);
    check("lw_c0_req", 32'(data_req), 32'd0);
    cyc();
    check("lw_c1_req",   32'(data_req),  32'd1);
    check("lw_c1_addr",  data_addr,      32'h0000_1004);
    check("lw_c1_size",  32'(data_size), 32'd2);
    check("lw_c1_wr",    32'(data_wr),   32'd0);
    check("lw_c1_wstrb", 32'(data_wstrb), 32'd0);
    check("lw_c1_stall", 32'(stall_o),   32'd1);
    cyc();
    check("lw_c2_req", 32'(data_req), 32'd1);
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0;
    check("lw_c3_req",   32'(data_req), 32'd0);
    check("lw_c3_stall", 32'(stall_o),  32'd1);
    cyc();
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1 check("lw_c4_stall", 32'(stall_o), 32'd1);
    cyc();
    data_data_ok = 1'b0;
    check("lw_c5_valid", 32'(load_valid), 32'd1);
    check("lw_c5_stall", 32'(stall_o),    32'd0);
    idle_inputs();
    cyc();

    // Sub-word loads: sign and zero extension
    do_load(3'b000, 32'h0000_2003, 32'h80AA_BBCC, 32'hFFFF_FF80);
    do_load(3'b100, 32'h0000_2003, 32'h80AA_BBCC, 32'h0000_0080);
    do_load(3'b001, 32'h0000_2002, 32'h80AA_BBCC, 32'hFFFF_80AA);
    do_load(3'b101, 32'h0000_2000, 32'h80AA_BBCC, 32'h0000_BBCC);
    do_load(3'b000, 32'h0000_2001, 32'h80AA_BBCC, 32'hFFFF_FFBB);
    check("hold_load_result", load_result, 32'hFFFF_FFBB);

    // SB and SH lane replication / strobes
    drive(1'b0, 1'b1, 3'b000, 32'h0000_3002, 32'h0000_0011);
    cyc();
    check("sb_wdata", data_wdata,     32'h1111_1111);
    check("sb_wstrb", 32'(data_wstrb), 32'b0100);
    check("sb_wr",    32'(data_wr),   32'd1);
    check("sb_size",  32'(data_size), 32'd0);
    bus_xact(32'h0);
    check("sb_no_load_valid", 32'(load_valid), 32'd0);
    idle_inputs(); cyc();
    drive(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h0000_5A3C);
    cyc();
    check("sh_wdata", data_wdata,      32'h5A3C_5A3C);
    check("sh_wstrb", 32'(data_wstrb), 32'b1100);
    check("sh_size",  32'(data_size),  32'd1);
    bus_xact(32'h0);
    idle_inputs(); cyc();
    drive(1'b0, 1'b1, 3'b010, 32'h0000_3004, 32'h1234_5678);
    cyc();
    check("sw_wdata", data_wdata,      32'h1234_5678);
    check("sw_wstrb", 32'(data_wstrb), 32'b1111);
    bus_xact(32'h0);
    idle_inputs(); cyc();

    // Misaligned accesses: exceptions, no request, no stall
    drive(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0);
    #1 check("lw_mis_adel", 32'(adel),    32'd1);
    check("lw_mis_ades",    32'(ades),    32'd0);
    check("lw_mis_badv",    badvaddr,     32'h0000_1002);
    check("lw_mis_stall",   32'(stall_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("lw_mis_no_req", 32'(data_req), 32'd0);
    end
    drive(1'b0, 1'b1, 3'b001, 32'h0000_1001, 32'h0);
    #1 check("sh_mis_ades", 32'(ades), 32'd1);
    check("sh_mis_adel",    32'(adel), 32'd0);
    cyc();
    check("sh_mis_no_req", 32'(data_req), 32'd0);
    drive(1'b1, 1'b0, 3'b011, 32'h0000_1001, 32'h0);
    #1 check("sz11_mis_adel", 32'(adel), 32'd1);
    idle_inputs(); cyc();

    // Flush while in REQ: request held, response drained, next load waits
    drive(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0);
    cyc();
    check("fl_req", 32'(data_req), 32'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0; idle_inputs();
    check("fl_req_held", 32'(data_req), 32'd1);
    cyc();
    check("fl_req_held2", 32'(data_req), 32'd1);
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0);
    sb.push_back(32'h1234_5678);
    #1 check("fl_cancel_stall", 32'(stall_o), 32'd1);
    check("fl_cancel_no_req", 32'(data_req), 32'd0);
    cyc();
    data_data_ok = 1'b1; data_rdata = 32'h0BAD_0BAD;
    check("fl_cancel_no_req2", 32'(data_req), 32'd0);
    cyc();
    data_data_ok = 1'b0;
    check("fl_idle_no_req", 32'(data_req), 32'd0);
    check("fl_no_valid",    32'(load_valid), 32'd0);
    #1 check("fl_idle_stall", 32'(stall_o), 32'd1);
    cyc();
    check("fl_next_req",  32'(data_req), 32'd1);
    check("fl_next_addr", data_addr,     32'h0000_7000);
    bus_xact(32'h1234_5678);
    idle_inputs(); cyc();

    // Zero-latency slave: addr_ok and data_ok together
    drive(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0);
    sb.push_back(32'hCAFE_F00D);
    cyc();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    check("zl_done_valid", 32'(load_valid), 32'd1);
    check("zl_done_stall", 32'(stall_o),    32'd0);
    idle_inputs(); cyc();

    // Async reset while in WAIT
    drive(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0);
    cyc();
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0;
    check("wr_wait_stall", 32'(stall_o), 32'd1);
    idle_inputs();
    rst = 1'b0;
    #1;
    check("wr_req",   32'(data_req),   32'd0);
    check("wr_wr",    32'(data_wr),    32'd0);
    check("wr_size",  32'(data_size),  32'd0);
    check("wr_addr",  data_addr,       32'd0);
    check("wr_wdata", data_wdata,      32'd0);
    check("wr_wstrb", 32'(data_wstrb), 32'd0);
    check("wr_lres",  load_result,     32'd0);
    check("wr_lval",  32'(load_valid), 32'd0);
    check("wr_stall", 32'(stall_o),    32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    drive(1'b1, 1'b0, 3'b010, 32'h0000_5008, 32'h0);
    #1 check("wr_idle_stall", 32'(stall_o), 32'd1);
    check("wr_idle_no_req", 32'(data_req), 32'd0);
    idle_inputs();
    drive(1'b1, 1'b0, 3'b010, 32'h0000_5008, 32'h0);
    sb.push_back(32'h0F0F_0F0F);
    bus_xact(32'h0F0F_0F0F);
    idle_inputs(); cyc(); cyc();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
